// File: rtl/l1_arb_pkg.sv
// Shared types and defaults for the L1 instruction/data memory port arbiter.
// Holds no logic, so it adds no latency and has no backpressure of its own.
package l1_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_I, ARB_D} arb_state_t;
  typedef enum logic {GNT_I, GNT_D} grant_t;

  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT      = 64;

  // Width of a counter that must hold values 0..limit without wrapping.
  function automatic int cnt_w(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/l1_arb_watchdog.sv
// Counts busy cycles without an ack; pulses expire on busy cycle TIMEOUT.
// Latency: expire is combinational on the last waiting cycle; nothing stalls it.
module l1_arb_watchdog
  import l1_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic ack,
  output logic expire
);

  localparam int WW = cnt_w(TIMEOUT);

  logic [WW-1:0] wd_cnt;

  assign expire = busy && !ack && (wd_cnt == WW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || !busy || ack || expire) wd_cnt <= '0;
    else                                 wd_cnt <= wd_cnt + 1'b1;
  end

endmodule

// File: rtl/l1_mem_port_arbiter.sv
// Shares one memory port between fetch (I) and data (D); ARB_ROUND_ROBIN_EN selects fair arbitration.
// Latency: 0 extra cycles on a 0-wait memory; waits stretch with m_ack, stalling the losing port.
module l1_mem_port_arbiter
  import l1_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_wait,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_wait,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              err
);

  arb_state_t state;
  logic       err_q;
  logic       expire;
  logic       busy;
  logic       pick_i, pick_d;
  logic       gnt_i, gnt_d;
  logic       done;

`ifdef ARB_ROUND_ROBIN_EN
  grant_t last_gnt;
  assign pick_d = d_req && (!i_req || last_gnt == GNT_I);
`else
  localparam int SW = cnt_w(STARVE_LIMIT);
  logic [SW-1:0] starve_cnt;
  // D normally wins as the older instruction, unless I has been passed over too often.
  assign pick_d = d_req && !(i_req && starve_cnt == SW'(STARVE_LIMIT));
`endif

  assign pick_i = i_req && !pick_d;
  assign busy   = (state != ARB_IDLE);
  assign gnt_i  = (state == ARB_I) || (state == ARB_IDLE && pick_i);
  assign gnt_d  = (state == ARB_D) || (state == ARB_IDLE && pick_d);
  assign done   = m_ack || expire;

  assign m_req   = !reset && (gnt_i || gnt_d);
  assign m_we    = !reset && gnt_d && d_we;
  assign m_addr  = gnt_d ? d_addr : i_addr;
  assign m_wdata = gnt_d ? d_wdata : '0;

  // A timed-out port is released with zero data rather than left stalled forever.
  assign i_wait  = !reset && i_req && !(gnt_i && done);
  assign d_wait  = !reset && d_req && !(gnt_d && done);
  assign i_rdata = (!reset && i_req && gnt_i && m_ack) ? m_rdata : '0;
  assign d_rdata = (!reset && d_req && gnt_d && m_ack && !d_we) ? m_rdata : '0;
  assign err     = err_q || (expire && !reset);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      err_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt <= GNT_I;
`else
      starve_cnt <= '0;
`endif
    end else begin
      if (expire) err_q <= 1'b1;
      case (state)
        ARB_IDLE: begin
          if (!m_ack) begin
            if (pick_d)      state <= ARB_D;
            else if (pick_i) state <= ARB_I;
          end
        end
        default: if (done) state <= ARB_IDLE;
      endcase
`ifdef ARB_ROUND_ROBIN_EN
      if (state == ARB_IDLE && (pick_i || pick_d))
        last_gnt <= pick_d ? GNT_D : GNT_I;
`else
      if (!i_req || (state == ARB_IDLE && pick_i))
        starve_cnt <= '0;
      else if (state == ARB_IDLE && pick_d && starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
`endif
    end
  end

  l1_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .busy   (busy),
    .ack    (m_ack),
    .expire (expire)
  );

endmodule
